// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared frame-buffer sizes and arbiter state encoding
package vga_pkg;

  localparam int VGA_ADDR_W = 16;
  localparam int VGA_DATA_W = 32;
  localparam int VGA_WORDS  = 48000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_CLEAR  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/vram_clear_seq.sv
// rtl/vram_clear_seq.sv - frame-clear request latch, word counter and busy flag
module vram_clear_seq
  import vga_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int WORDS  = VGA_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_start,
  input  logic [15:0]       clear_color,
  input  logic              step_i,
  output logic              pending_o,
  output logic              busy_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] cnt_o,
  output logic [15:0]       color_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  logic              pending_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [15:0]       color_q;

  assign pending_o = pending_q;
  assign busy_o    = busy_q;
  assign cnt_o     = cnt_q;
  assign color_o   = color_q;
  assign last_o    = (cnt_q == LAST_ADDR);

  // busy outlives pending by one cycle so it covers the final write on the bus
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      color_q   <= '0;
    end else begin
      done_q <= step_i && last_o;
      if (clear_start && !busy_q) begin
        pending_q <= 1'b1;
        busy_q    <= 1'b1;
        color_q   <= clear_color;
        cnt_q     <= '0;
      end
      if (step_i) begin
        if (last_o) begin
          cnt_q     <= '0;
          pending_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (done_q) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - two-requester round-robin VRAM arbiter with frame clear
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W,
  parameter int WORDS  = VGA_WORDS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              we_0,
  output logic              ack_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              rvalid_0,
  input  logic              valid_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic              we_1,
  output logic              ack_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic              rvalid_1,
  input  logic              clear_start,
  input  logic [15:0]       clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  output logic              vram_wren,
  output logic              vram_rden,
  input  logic [DATA_W-1:0] vram_q
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              cur_q, cur_d;
  logic              we_q, we_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d, rden_q, rden_d;
  logic              pick, clr_step;

  logic              clr_pending, clr_last;
  logic [ADDR_W-1:0] clr_cnt;
  logic [15:0]       clr_color;

  vram_clear_seq #(.ADDR_W(ADDR_W), .WORDS(WORDS)) u_clear (
    .clock       (clock),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .step_i      (clr_step),
    .pending_o   (clr_pending),
    .busy_o      (clear_busy),
    .last_o      (clr_last),
    .cnt_o       (clr_cnt),
    .color_o     (clr_color)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_d    = cur_q;
    we_d     = we_q;
    ack_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    clr_step = 1'b0;
    // on a tie the requester not served last wins
    pick     = (valid_0 && valid_1) ? ~last_q : valid_1;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_pending) begin
          state_d = ST_CLEAR;
        end else if (valid_0 || valid_1) begin
          cur_d       = pick;
          last_d      = pick;
          we_d        = pick ? we_1 : we_0;
          addr_d      = pick ? addr_1 : addr_0;
          data_d      = pick ? wdata_1 : wdata_0;
          wren_d      = we_d;
          rden_d      = !we_d;
          ack_d[pick] = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = we_q ? ST_IDLE : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (cur_q) rdata1_d = vram_q;
        else       rdata0_d = vram_q;
        rvalid_d[cur_q] = 1'b1;
        state_d         = ST_IDLE;
      end
      ST_CLEAR: begin
        clr_step = 1'b1;
        wren_d   = 1'b1;
        addr_d   = clr_cnt;
        data_d   = DATA_W'({clr_color, clr_color});
        if (clr_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      cur_q    <= 1'b0;
      we_q     <= 1'b0;
      ack_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
    end
  end

  assign ack_0     = ack_q[0];
  assign ack_1     = ack_q[1];
  assign rvalid_0  = rvalid_q[0];
  assign rvalid_1  = rvalid_q[1];
  assign rdata_0   = rdata0_q;
  assign rdata_1   = rdata1_q;
  assign vram_addr = addr_q;
  assign vram_data = data_q;
  assign vram_wren = wren_q;
  assign vram_rden = rden_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with a behavioural RAM
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_0, we_0, valid_1, we_1;
  logic [15:0] addr_0, addr_1;
  logic [31:0] wdata_0, wdata_1;
  logic        ack_0, rvalid_0, ack_1, rvalid_1;
  logic [31:0] rdata_0, rdata_1;
  logic        clear_start;
  logic [15:0] clear_color;
  logic        clear_busy;
  logic [15:0] vram_addr;
  logic [31:0] vram_data;
  logic        vram_wren, vram_rden;
  logic [31:0] vram_q;

  vram_arbiter dut (
    .clock(clock), .reset(reset),
    .valid_0(valid_0), .addr_0(addr_0), .wdata_0(wdata_0), .we_0(we_0),
    .ack_0(ack_0), .rdata_0(rdata_0), .rvalid_0(rvalid_0),
    .valid_1(valid_1), .addr_1(addr_1), .wdata_1(wdata_1), .we_1(we_1),
    .ack_1(ack_1), .rdata_1(rdata_1), .rvalid_1(rvalid_1),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_wren(vram_wren),
    .vram_rden(vram_rden), .vram_q(vram_q)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a ^ 16'hA5A5, ~a};
  endfunction

  // RAM model: registered read, data valid the cycle after rden
  bit [31:0] mem [65536];
  bit        mem_wr [65536];
  always @(posedge clock) begin
    if (vram_rden) vram_q <= mem_wr[vram_addr] ? mem[vram_addr] : pat(vram_addr);
    if (vram_wren) begin
      mem[vram_addr]    <= vram_data;
      mem_wr[vram_addr] <= 1'b1;
    end
  end

  bit [31:0] exp_mem [65536];
  bit        exp_wr [65536];
  function automatic logic [31:0] exp_rd(input logic [15:0] a);
    return exp_wr[a] ? exp_mem[a] : pat(a);
  endfunction

  logic [47:0] wr_q[$];
  logic [31:0] rd_q0[$];
  logic [31:0] rd_q1[$];
  int          clr_n = 0;
  int          clr_base = 0;
  logic [15:0] clr_col = 16'h0;
  int          cyc = 0;
  int          rv0_cyc = 0;
  int          first_clr_cyc = 0;
  logic        prev_nc_wr = 1'b0;
  logic        prev_rd = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      cyc++;
      if (vram_wren || vram_rden) check_eq("wr_rd_mx", 64'(vram_wren & vram_rden), 0);
      if (vram_wren && clear_busy) begin
        check_eq("clr_word", {vram_addr, vram_data}, {16'(clr_n - clr_base), clr_col, clr_col});
        if (clr_n == clr_base) first_clr_cyc = cyc;
        clr_n++;
      end else if (vram_wren) begin
        check_eq("wr_pulse", 64'(prev_nc_wr), 0);
        if (wr_q.size() == 0) check_eq("wr_extra", 1, 0);
        else check_eq("wr_cmd", {vram_addr, vram_data}, wr_q.pop_front());
      end
      if (vram_rden) check_eq("rd_pulse", 64'(prev_rd), 0);
      prev_nc_wr = vram_wren && !clear_busy;
      prev_rd    = vram_rden;
      if (ack_0 || ack_1) check_eq("ack_mx", 64'(ack_0 & ack_1), 0);
      if (rvalid_0 || rvalid_1) check_eq("rv_mx", 64'(rvalid_0 & rvalid_1), 0);
      if (rvalid_0) begin
        rv0_cyc = cyc;
        if (rd_q0.size() == 0) check_eq("rv0_extra", 1, 0);
        else check_eq("rdata_0", rdata_0, rd_q0.pop_front());
      end
      if (rvalid_1) begin
        if (rd_q1.size() == 0) check_eq("rv1_extra", 1, 0);
        else check_eq("rdata_1", rdata_1, rd_q1.pop_front());
      end
    end
  end

  task automatic req_issue(input int k, input bit we, input logic [15:0] a, input logic [31:0] d,
                           input int exp_lat, input int budget);
    int lat;
    bit got;
    if (k == 0) begin valid_0 = 1'b1; we_0 = we; addr_0 = a; wdata_0 = d; end
    else        begin valid_1 = 1'b1; we_1 = we; addr_1 = a; wdata_1 = d; end
    if (we) begin
      wr_q.push_back({a, d});
      exp_mem[a] = d;
      exp_wr[a]  = 1'b1;
    end else if (k == 0) rd_q0.push_back(exp_rd(a));
    else rd_q1.push_back(exp_rd(a));
    lat = 0;
    got = 1'b0;
    while (!got && lat < budget) begin
      @(negedge clock);
      lat++;
      got = (k == 0) ? ack_0 : ack_1;
    end
    check_eq(k == 0 ? "ack0_lat" : "ack1_lat", lat, exp_lat);
    if (k == 0) valid_0 = 1'b0;
    else        valid_1 = 1'b0;
  endtask

  task automatic wait_rv(input int k, input int exp_lat);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clock);
      lat++;
      got = (k == 0) ? rvalid_0 : rvalid_1;
    end
    check_eq(k == 0 ? "rv0_lat" : "rv1_lat", lat, exp_lat);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    valid_0 = 0; we_0 = 0; addr_0 = 0; wdata_0 = 0;
    valid_1 = 0; we_1 = 0; addr_1 = 0; wdata_1 = 0;
    clear_start = 0; clear_color = 0;
    repeat (3) @(negedge clock);
    check_eq("rst_ack", {ack_0, ack_1, rvalid_0, rvalid_1}, 0);
    check_eq("rst_wren", vram_wren, 0);
    check_eq("rst_rden", vram_rden, 0);
    check_eq("rst_busy", clear_busy, 0);
    check_eq("rst_addr", vram_addr, 0);
    check_eq("rst_data", vram_data, 0);
    check_eq("rst_rdata", {rdata_0, rdata_1}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single write, then a back-to-back write paced at one grant per 2 cycles
    req_issue(0, 1, 16'h0010, 32'hF800F800, 1, 10);
    req_issue(0, 1, 16'h0011, 32'h12345678, 2, 10);
    repeat (2) @(negedge clock);
    req_issue(1, 1, 16'h0002, 32'hCAFEF00D, 1, 10);
    repeat (2) @(negedge clock);

    // ties: pointer last=1 so k=0 first, k=1 three cycles later
    fork
      begin req_issue(0, 0, 16'h0001, 0, 1, 10); wait_rv(0, 2); end
      begin req_issue(1, 0, 16'h0002, 0, 4, 10); wait_rv(1, 2); end
    join
    @(negedge clock);
    fork
      begin req_issue(0, 0, 16'h0003, 0, 1, 10); wait_rv(0, 2); end
      begin req_issue(1, 0, 16'h0004, 0, 4, 10); wait_rv(1, 2); end
    join
    @(negedge clock);
    req_issue(0, 0, 16'h0005, 0, 1, 10);
    wait_rv(0, 2);
    @(negedge clock);
    fork
      begin req_issue(0, 0, 16'h0006, 0, 4, 10); wait_rv(0, 2); end
      begin req_issue(1, 0, 16'h0007, 0, 1, 10); wait_rv(1, 2); end
    join
    repeat (4) @(negedge clock);
    check_eq("rdata0_hold", rdata_0, exp_rd(16'h0006));
    check_eq("rdata1_hold", rdata_1, exp_rd(16'h0007));

    // clear requested while a read sits in ISSUE; k=1 waits out the whole clear
    clr_base = clr_n;
    clr_col  = 16'h07E0;
    req_issue(0, 0, 16'h0020, 0, 1, 10);
    clear_start = 1'b1;
    clear_color = 16'h07E0;
    for (int i = 0; i < 48000; i++) begin
      exp_mem[i] = 32'h07E007E0;
      exp_wr[i]  = 1'b1;
    end
    fork
      wait_rv(0, 2);
      begin
        @(negedge clock);
        clear_start = 1'b0;
        check_eq("busy_set", clear_busy, 1);
        req_issue(1, 1, 16'h0100, 32'hBEEF0001, 48003, 60000);
        check_eq("busy_at_ack", clear_busy, 0);
      end
      begin
        repeat (500) @(negedge clock);
        clear_start = 1'b1;
        clear_color = 16'hFFFF;
        @(negedge clock);
        clear_start = 1'b0;
      end
    join
    repeat (3) @(negedge clock);
    check_eq("clr_count", clr_n - clr_base, 48000);
    check_eq("clr_after_rv", 64'(first_clr_cyc > rv0_cyc), 1);
    check_eq("busy_done", clear_busy, 0);

    // reset in the middle of a clear
    clr_base = clr_n;
    clr_col  = 16'h1234;
    clear_start = 1'b1;
    clear_color = 16'h1234;
    @(negedge clock);
    clear_start = 1'b0;
    n = 0;
    while (!(vram_wren && vram_addr == 16'd1000) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check_eq("clr_at_1000", {vram_wren, vram_addr}, {1'b1, 16'd1000});
    #2 reset = 1'b0;
    #1;
    check_eq("rstmid_wren", vram_wren, 0);
    check_eq("rstmid_busy", clear_busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("clr_abandon", clr_n - clr_base, 1001);
    check_eq("rst_no_ack", {ack_0, ack_1, rvalid_0, rvalid_1}, 0);
    req_issue(0, 1, 16'h0005, 32'h0BADCAFE, 1, 10);
    repeat (4) @(negedge clock);

    check_eq("wr_q_left", wr_q.size(), 0);
    check_eq("rd_q0_left", rd_q0.size(), 0);
    check_eq("rd_q1_left", rd_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, frame-buffer word address width; DATA_W, default 32, word width (two RGB565 pixels); WORDS, default 48000, words in one 400x240 frame.
REQ-002 SHALL have ports (clock and reset first): clock  in  1  single system clock, all logic on rising edge; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have, per requester k in {0,1}: valid_k  in  1  request pending; addr_k  in  ADDR_W  word address; wdata_k  in  DATA_W  write data; we_k  in  1  1=write, 0=read; ack_k  out  1  one-cycle command-accepted pulse; rdata_k  out  DATA_W  read data; rvalid_k  out  1  one-cycle read-data-valid pulse.
REQ-004 SHALL have: clear_start  in  1  frame-clear request pulse; clear_color  in  16  RGB565 fill colour; clear_busy  out  1  clear in progress.
REQ-005 SHALL have, to the frame-buffer write port: vram_addr  out  ADDR_W; vram_data  out  DATA_W; vram_wren  out  1; vram_rden  out  1; vram_q  in  DATA_W, valid the cycle after the cycle vram_rden is high.

Function
REQ-006 SHALL implement an FSM with states IDLE, ISSUE, RDWAIT, CLEAR.
REQ-007 SHALL give a pending clear priority: in IDLE with clear pending, go to CLEAR; no requester is granted.
REQ-008 SHALL otherwise, in IDLE, grant one requester with valid high: if both are valid, grant the one not granted last (round-robin); the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-009 SHALL, on a grant at edge E, register vram_addr/vram_data/vram_wren/vram_rden from the granted requester, assert ack_k for exactly the cycle after E, and enter ISSUE.
REQ-010 SHALL drive vram_wren and vram_rden high for exactly one cycle per granted transaction.
REQ-011 SHALL, from ISSUE, go to IDLE for a write and to RDWAIT for a read.
REQ-012 SHALL, in RDWAIT, capture vram_q into rdata_k of the granted requester, pulse rvalid_k in the following cycle, and go to IDLE.
REQ-013 SHALL deliver latency as follows: ack 1 cycle after valid is sampled in IDLE; rvalid 3 cycles after; writes sustain one grant per 2 cycles and reads one per 3 cycles.
REQ-014 SHALL never grant a request in ISSUE, RDWAIT or CLEAR; requesters hold valid and their fields until ack.
REQ-015 SHALL latch clear_start in any state when clear_busy is low; clear_start while clear_busy is high SHALL be ignored.
REQ-016 SHALL let an in-flight transaction (ISSUE or RDWAIT) complete, including rvalid, before CLEAR begins.
REQ-017 SHALL set clear_busy high from the cycle after clear_start is sampled until the cycle after the last clear write.
REQ-018 SHALL, in CLEAR, write {clear_color, clear_color} to addresses 0..WORDS-1 in ascending order, one word per cycle, with vram_wren continuously high and clear_color sampled once at clear_start.
REQ-019 SHALL, after writing address WORDS-1, deassert vram_wren, leave the clear counter at 0 with no wrap-around write, and return to IDLE.
REQ-020 SHALL keep rdata_k holding its last captured value between reads.
REQ-021 SHALL keep ack_k and rvalid_k mutually exclusive between requesters.

Reset
REQ-022 SHALL, on reset asserted low (asynchronously), set: state IDLE; ack_k, rvalid_k, vram_wren, vram_rden, clear_busy and the clear pending flag 0; vram_addr, vram_data, rdata_k and the clear counter 0; last-granted pointer 1.
REQ-023 SHALL, on reset mid-transaction or mid-clear, abandon the operation with no further RAM writes and produce no ack/rvalid for it after release.

Structure
REQ-024 SHALL place the FSM state encoding and the WORDS/ADDR_W/DATA_W defaults in the shared package vga_pkg.
REQ-025 SHALL use one sub-module, vram_clear_seq, holding the clear counter, the pending flag and the clear_busy logic; arbitration and FSM stay in vram_arbiter.

Verification
REQ-026 Write k=0, addr 0x0010, data 0xF800F800 -> ack_0 1 cycle later; vram_wren one cycle with addr 0x0010 and that data.
REQ-027 Both valid: reads at 0x0001 (k=0) and 0x0002 (k=1) -> k=0 served first, then k=1; rvalid_0 then rvalid_1 with the correct RAM model data; the next tie goes to k=0.
REQ-028 clear_start with colour 0x07E0 while idle -> 48000 consecutive writes of 0x07E007E0 to addresses 0..47999; clear_busy high throughout; a valid_1 held during the clear gets its ack only after clear_busy falls.
REQ-029 clear_start during a read's ISSUE -> the read completes with rvalid, then the clear starts; a second clear_start during the clear is ignored (exactly 48000 writes).
REQ-030 Reset low at clear address 1000 -> vram_wren 0 immediately, clear_busy 0; after release a write to 0x0005 is acked normally.
